mdu_iterative: RTL
==================

// Module: mdu_iterative
// PURPOSE
//  Iterative multiply/divide unit executing RV64M ops selected by the 5-bit ALU control code from decode.
//  Sits beside the single-cycle ALU in EX. Multicycle ops stall the pipe via a valid/ready handshake.
//  Shift-add multiplier and restoring divider; one bit per cycle; sign fix-up at the end.
// PARAMETERS
//  XLEN  64  operand/result width; W ops use XLEN/2 = 32
// PORTS
//  i_clk           in   1     clock, all state on rising edge
//  i_rst           in   1     synchronous active-high reset
//  i_valid         in   1     request valid
//  o_ready         out  1     unit can accept a request (state IDLE)
//  i_alu_control   in   5     op code (table below), sampled on accept
//  i_src_1         in   XLEN  rs1 operand, sampled on accept
//  i_src_2         in   XLEN  rs2 operand, sampled on accept
//  i_flush         in   1     abort in-flight op (pipeline flush)
//  o_valid         out  1     result valid
//  i_ready         in   1     consumer takes result
//  o_result        out  XLEN  result; held stable while o_valid && !i_ready
// BEHAVIOUR
//  Op codes: 01111 MUL, 10000 MULH, 10001 MULHSU, 10010 MULHU, 10011 DIV, 10100 DIVU,
//   10101 REM, 10110 REMU, 10111 MULW, 11000 DIVW, 11001 DIVUW, 11010 REMW, 11011 REMUW.
//  Any other code: accepted, fast path, result 0.
//  Reset: state IDLE, o_ready=1, o_valid=0, o_result=0, counters/accumulators 0.
//  Accept: i_valid && o_ready on an edge. Operands and op are latched. Inputs are don't-care afterwards.
//  FSM: IDLE -> PREP (1 cyc: magnitudes, signs, special-case check) -> BUSY (N cyc) -> DONE.
//   N = XLEN for 64-bit ops and 32 for W ops.
//   PREP goes straight to DONE for fast-path cases.
//   DONE: o_valid=1; DONE -> IDLE on i_ready.
//  Latency, normal ops: o_valid rises N+2 cycles after the accept edge.
//  Latency, fast path: o_valid rises 2 cycles after the accept edge.
//  Back-to-back: o_ready=1 is asserted in the cycle after the DONE handshake, never in the same cycle.
//  Operand prep for W ops:
//   - use src[31:0].
//   - signed ops sign-extend; unsigned ops (DIVUW, REMUW) zero-extend.
//  Multiply:
//   - 2*XLEN product of magnitudes; negate if the operand signs differ.
//   - MULHSU: rs1 signed, rs2 unsigned.
//   - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
//   - MULW returns product[31:0] sign-extended to XLEN.
//  Divide:
//   - restoring division on magnitudes.
//   - quotient negated if the dividend and divisor signs differ (signed ops only).
//   - remainder takes the sign of the dividend.
//  Fast path, divisor == 0 (after W truncation):
//   - quotient = all ones (-1).
//   - remainder = dividend (after W prep).
//  Fast path, signed overflow (dividend = most-negative, divisor = -1):
//   - quotient = dividend, remainder = 0.
//   - for W ops, most-negative means 0x8000_0000.
//  All W results: result[31:0] sign-extended to XLEN. This applies to DIVUW/REMUW too, per the ISA.
//  Flush:
//   - i_flush in any state -> IDLE at the next edge, o_valid=0, no result delivered.
//   - i_flush has priority over accept and over the DONE handshake.
//  Reset mid-op: same as flush, plus o_result cleared.
//  No bubble on result: o_result is registered and does not change in DONE.
// TESTING
//  MUL 7*-3 (64b): o_valid 66 cyc after accept, result 0xFFFF_FFFF_FFFF_FFEB.
//  MULH/MULHU/MULHSU, src1=src2=0xFFFF_FFFF_FFFF_FFFF -> 0, 0xFFFF_FFFF_FFFF_FFFE, 0xFFFF_FFFF_FFFF_FFFF.
//  DIV -7/2 -> quotient 0xFFFF_FFFF_FFFF_FFFD. REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF.
//   DIVUW 0x8000_0000/1 -> 0xFFFF_FFFF_8000_0000, valid 34 cyc after accept.
//  Div by 0: DIVU 5/0 -> all ones, REMU 5/0 -> 5, valid 2 cyc after accept.
//   Overflow: DIV 0x8000_0000_0000_0000/-1 -> 0x8000_0000_0000_0000; REMW 0x8000_0000/-1 -> 0.
//  Handshake: hold i_ready=0 for 10 cycles in DONE -> o_valid, o_result stable, o_ready=0.
//   Then i_ready=1 -> o_ready=1 next cycle; back-to-back accept works.
//  Flush at BUSY cycle 20 -> IDLE next cycle, no o_valid.
//   A new DIVU 100/7 then returns 14. Sync reset mid-op gives the same recovery.

Source files
------------

// File: rtl/mdu_iterative.sv
// Iterative RV64M multiply/divide unit: shift-add multiplier and restoring divider,
// one bit per cycle, followed by a sign fix-up cycle before the result is presented.
module mdu_iterative #(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_alu_control,
  input  logic [XLEN-1:0] i_src_1,
  input  logic [XLEN-1:0] i_src_2,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result
);

  localparam int HW = XLEN / 2;
  localparam int CW = $clog2(XLEN);

  localparam logic [4:0] OP_MUL    = 5'b01111;
  localparam logic [4:0] OP_MULH   = 5'b10000;
  localparam logic [4:0] OP_MULHSU = 5'b10001;
  localparam logic [4:0] OP_MULHU  = 5'b10010;
  localparam logic [4:0] OP_DIV    = 5'b10011;
  localparam logic [4:0] OP_DIVU   = 5'b10100;
  localparam logic [4:0] OP_REM    = 5'b10101;
  localparam logic [4:0] OP_REMU   = 5'b10110;
  localparam logic [4:0] OP_MULW   = 5'b10111;
  localparam logic [4:0] OP_DIVW   = 5'b11000;
  localparam logic [4:0] OP_DIVUW  = 5'b11001;
  localparam logic [4:0] OP_REMW   = 5'b11010;
  localparam logic [4:0] OP_REMUW  = 5'b11011;

  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};

  // FIN registers the sign-corrected result so o_result is stable throughout DONE.
  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_BUSY,
    S_FIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          op_q, op_d;
  logic [XLEN-1:0]     src1_q, src1_d;
  logic [XLEN-1:0]     src2_q, src2_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                fast_q, fast_d;
  logic [XLEN-1:0]     fast_res_q, fast_res_d;
  logic                neg_ab_q, neg_ab_d;
  logic                neg_a_q, neg_a_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     quo_q, quo_d;
  logic [XLEN-1:0]     dvsr_q, dvsr_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic dec_valid, dec_mul, dec_rem, dec_w, dec_sa, dec_sb, dec_hi;

  always_comb begin
    dec_valid = 1'b0;
    dec_mul   = 1'b0;
    dec_rem   = 1'b0;
    dec_w     = 1'b0;
    dec_sa    = 1'b0;
    dec_sb    = 1'b0;
    dec_hi    = 1'b0;
    case (op_q)
      OP_MUL:    begin dec_valid = 1'b1; dec_mul = 1'b1; dec_sa = 1'b1; dec_sb = 1'b1; end
      OP_MULH:   begin dec_valid = 1'b1; dec_mul = 1'b1; dec_sa = 1'b1; dec_sb = 1'b1; dec_hi = 1'b1; end
      OP_MULHSU: begin dec_valid = 1'b1; dec_mul = 1'b1; dec_sa = 1'b1; dec_hi = 1'b1; end
      OP_MULHU:  begin dec_valid = 1'b1; dec_mul = 1'b1; dec_hi = 1'b1; end
      OP_DIV:    begin dec_valid = 1'b1; dec_sa = 1'b1; dec_sb = 1'b1; end
      OP_DIVU:   begin dec_valid = 1'b1; end
      OP_REM:    begin dec_valid = 1'b1; dec_rem = 1'b1; dec_sa = 1'b1; dec_sb = 1'b1; end
      OP_REMU:   begin dec_valid = 1'b1; dec_rem = 1'b1; end
      OP_MULW:   begin dec_valid = 1'b1; dec_mul = 1'b1; dec_w = 1'b1; dec_sa = 1'b1; dec_sb = 1'b1; end
      OP_DIVW:   begin dec_valid = 1'b1; dec_w = 1'b1; dec_sa = 1'b1; dec_sb = 1'b1; end
      OP_DIVUW:  begin dec_valid = 1'b1; dec_w = 1'b1; end
      OP_REMW:   begin dec_valid = 1'b1; dec_rem = 1'b1; dec_w = 1'b1; dec_sa = 1'b1; dec_sb = 1'b1; end
      OP_REMUW:  begin dec_valid = 1'b1; dec_rem = 1'b1; dec_w = 1'b1; end
      default:   ;
    endcase
  end

  // Operand preparation: W truncation/extension, magnitudes and special cases.
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, prep_fast_res;
  logic            neg_a, neg_b, div_zero, div_ovf, prep_fast;

  always_comb begin
    a_ext     = dec_w ? {{HW{dec_sa & src1_q[HW-1]}}, src1_q[HW-1:0]} : src1_q;
    b_ext     = dec_w ? {{HW{dec_sb & src2_q[HW-1]}}, src2_q[HW-1:0]} : src2_q;
    neg_a     = dec_sa & a_ext[XLEN-1];
    neg_b     = dec_sb & b_ext[XLEN-1];
    mag_a     = neg_a ? -a_ext : a_ext;
    mag_b     = neg_b ? -b_ext : b_ext;
    div_zero  = ~dec_mul & (b_ext == '0);
    div_ovf   = ~dec_mul & dec_sa & (a_ext == (dec_w ? MIN_W : MIN_X)) & (b_ext == '1);
    prep_fast = ~dec_valid | div_zero | div_ovf;
    prep_fast_res = '0;
    if (dec_valid && div_zero) begin
      prep_fast_res = dec_rem ? a_ext : '1;
    end else if (dec_valid && div_ovf) begin
      prep_fast_res = dec_rem ? '0 : a_ext;
    end
  end

  // One iteration of each engine.
  logic [2*XLEN-1:0] mul_sum;
  logic [XLEN:0]     rem_shift, div_diff;
  logic [XLEN-1:0]   rem_next, quo_next;

  always_comb begin
    mul_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    rem_shift = {rem_q, quo_q[XLEN-1]};
    div_diff  = rem_shift - {1'b0, dvsr_q};
    rem_next  = div_diff[XLEN] ? rem_shift[XLEN-1:0] : div_diff[XLEN-1:0];
    quo_next  = {quo_q[XLEN-2:0], ~div_diff[XLEN]};
  end

  // Sign fix-up and result selection.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_raw, fin_result;

  always_comb begin
    prod_fix = neg_ab_q ? -acc_q : acc_q;
    quo_fix  = neg_ab_q ? -quo_q : quo_q;
    rem_fix  = neg_a_q ? -rem_q : rem_q;
    if (fast_q) begin
      fin_raw = fast_res_q;
    end else if (dec_mul) begin
      fin_raw = dec_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end else begin
      fin_raw = dec_rem ? rem_fix : quo_fix;
    end
    fin_result = dec_w ? {{HW{fin_raw[HW-1]}}, fin_raw[HW-1:0]} : fin_raw;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    cnt_d      = cnt_q;
    fast_d     = fast_q;
    fast_res_d = fast_res_q;
    neg_ab_d   = neg_ab_q;
    neg_a_d    = neg_a_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    result_d   = result_q;
    if (i_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            state_d = S_PREP;
            op_d    = i_alu_control;
            src1_d  = i_src_1;
            src2_d  = i_src_2;
          end
        end
        S_PREP: begin
          fast_d     = prep_fast;
          fast_res_d = prep_fast_res;
          neg_ab_d   = neg_a ^ neg_b;
          neg_a_d    = neg_a;
          acc_d      = '0;
          mcand_d    = {{XLEN{1'b0}}, mag_a};
          mplier_d   = mag_b;
          rem_d      = '0;
          // W dividends start at the top so their MSB is consumed first.
          quo_d      = dec_w ? {mag_a[HW-1:0], {HW{1'b0}}} : mag_a;
          dvsr_d     = mag_b;
          cnt_d      = dec_w ? CW'(HW - 1) : CW'(XLEN - 1);
          state_d    = prep_fast ? S_FIN : S_BUSY;
        end
        S_BUSY: begin
          if (dec_mul) begin
            acc_d    = mul_sum;
            mcand_d  = {mcand_q[2*XLEN-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[XLEN-1:1]};
          end else begin
            rem_d = rem_next;
            quo_d = quo_next;
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_d = S_FIN;
          end
        end
        S_FIN: begin
          result_d = fin_result;
          state_d  = S_DONE;
        end
        S_DONE: begin
          if (i_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      cnt_q      <= '0;
      fast_q     <= 1'b0;
      fast_res_q <= '0;
      neg_ab_q   <= 1'b0;
      neg_a_q    <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      cnt_q      <= cnt_d;
      fast_q     <= fast_d;
      fast_res_q <= fast_res_d;
      neg_ab_q   <= neg_ab_d;
      neg_a_q    <= neg_a_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      result_q   <= result_d;
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = (state_q == S_DONE);
  assign o_result = result_q;

endmodule
